// File: rtl/dmem_responder_if.sv
// Memory-stage <-> data-memory responder bus.
// master = memory stage (issues requests), slave = dmem_responder.
interface dmem_responder_if;
  logic        REQ_i;
  logic        WRT_ENA_i;
  logic [2:0]  FUNCT3_i;
  logic [31:0] ADDR_i;
  logic [31:0] WRT_DATA_i;
  logic [31:0] RD_DATA_o;
  logic        ACK_o;
  logic        BUSY_o;
  logic        ERR_o;

  modport master (
    output REQ_i, WRT_ENA_i, FUNCT3_i, ADDR_i, WRT_DATA_i,
    input  RD_DATA_o, ACK_o, BUSY_o, ERR_o
  );

  modport slave (
    input  REQ_i, WRT_ENA_i, FUNCT3_i, ADDR_i, WRT_DATA_i,
    output RD_DATA_o, ACK_o, BUSY_o, ERR_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for an RV32I memory stage.
// A request is captured in IDLE, waits WAIT_CYCLES+1 cycles in ACCESS, performs
// the storage access on the last ACCESS edge and acknowledges for one cycle in RESP.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses are
// rejected with ERR_o instead of being silently aligned down.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           accept, fire;

  logic [AW+1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic           we_q;
  logic [2:0]     f3_q;

  logic [31:0]    rd_q;
  logic           err_q;

  logic [31:0]    mem [DEPTH_WORDS];

  logic [AW-1:0]  idx;
  logic           legal, err_c;
  logic [1:0]     off;
  logic [3:0]     be;
  logic [31:0]    wlane, rword;

  // Address bits above the storage window alias and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.ADDR_i[31:AW+2];

  // Byte offset actually used: sub-size address bits are forced to zero.
  function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    return a;
      2'd1:    return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  // Byte-lane write mask for SB/SH/SW.
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] o);
    case (sz)
      2'd0:    return 4'b0001 << o;
      2'd1:    return o[1] ? 4'b1100 : 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the low-order store bytes onto every lane so the mask picks the right one.
  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Select the addressed lane and sign/zero extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w,
                                           input logic [1:0] o);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    case (o)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h  = o[1] ? w[31:16] : w[15:0];
    bs = signed'(b);
    hs = signed'(h);
    case (f3)
      3'd0:    return 32'(bs);
      3'd1:    return 32'(hs);
      3'd2:    return w;
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  // State and wait-counter register; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in ACCESS, single RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.REQ_i) begin
          accept  = 1'b1;
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          fire    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture on the acceptance edge; pure data, so no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q  <= bus.ADDR_i[AW+1:0];
      wdata_q <= bus.WRT_DATA_i;
      we_q    <= bus.WRT_ENA_i;
      f3_q    <= bus.FUNCT3_i;
    end
  end

  // Decode of the captured request: legality, lane offset, write mask, read word.
`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis;
`endif
  always_comb begin
    legal = we_q ? (f3_q inside {3'd0, 3'd1, 3'd2})
                 : (f3_q inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef DMEM_MISALIGN_TRAP_EN
    mis   = ((f3_q[1:0] == 2'd1) && addr_q[0]) ||
            ((f3_q[1:0] == 2'd2) && (addr_q[1:0] != 2'b00));
    err_c = !legal || mis;
`else
    err_c = !legal;
`endif
    off   = align_off(f3_q[1:0], addr_q[1:0]);
    be    = byte_en(f3_q[1:0], off);
    wlane = store_lanes(f3_q[1:0], wdata_q);
    idx   = addr_q[AW+1:2];
    rword = mem[idx];
  end

  // Load result and error status, updated only on the final ACCESS edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= 32'd0;
      err_q <= 1'b0;
    end else if (fire) begin
      err_q <= err_c;
      rd_q  <= (we_q || err_c) ? 32'd0 : load_ext(f3_q, rword, off);
    end
  end

  // Storage write; contents survive reset, but a reset on the final edge cancels it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && fire && we_q && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign bus.RD_DATA_o = rd_q;
  assign bus.ERR_o     = err_q;
  assign bus.ACK_o     = (state_q == RESP);
  assign bus.BUSY_o    = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic checked
// against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int WA = 2;
  localparam int WB = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WA)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WB)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] mbytes [1024];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
  endtask

  // Reference: byte memory of 1024 bytes (256 words), address bits above 9 alias.
  function automatic void model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wd, output logic [31:0] rd,
                                   output logic er);
    int size;
    int a;
    bit legal;
    bit mis;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    a     = int'(addr[9:0]);
    mis   = (a % size) != 0;
    er    = !legal;
    rd    = 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (mis) er = 1'b1;
`else
    if (mis) a = a - (a % size);
`endif
    if (er) return;
    if (we) begin
      for (int i = 0; i < size; i++) mbytes[a + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mbytes[a + i];
      if (!f3[2] && size < 4 && v[8*size-1]) begin
        for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      rd = v;
    end
  endfunction

  // One transaction on DUT A; entered and left 1 time unit after a rising edge with DUT idle.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int  n;
    int  busy;
    bit  got;
    bus_a.REQ_i      = 1'b1;
    bus_a.WRT_ENA_i  = we;
    bus_a.FUNCT3_i   = f3;
    bus_a.ADDR_i     = addr;
    bus_a.WRT_DATA_i = wd;
    @(posedge clk); #1;
    bus_a.REQ_i      = 1'b0;
    bus_a.ADDR_i     = $urandom;
    bus_a.WRT_DATA_i = $urandom;
    bus_a.FUNCT3_i   = 3'($urandom);
    n    = 0;
    busy = 0;
    got  = 0;
    rd   = 32'd0;
    er   = 1'b0;
    while (!got && n < 40) begin
      if (bus_a.BUSY_o) busy++;
      if (bus_a.ACK_o) begin
        got = 1;
        rd  = bus_a.RD_DATA_o;
        er  = bus_a.ERR_o;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      return;
    end
    chk("ack_latency", n, WA + 1);
    chk("busy_cycles", busy, WA + 2);
    @(posedge clk); #1;
    chk("ack_pulse", {30'd0, bus_a.ACK_o, bus_a.BUSY_o}, 32'd0);
    chk("rd_hold", bus_a.RD_DATA_o, rd);
  endtask

  // Run on the DUT and the model, then compare load data and error status.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd);
    logic [31:0] erd;
    logic        eer;
    logic        er;
    run_op(we, f3, addr, wd, rd, er);
    model_op(we, f3, addr, wd, erd, eer);
    chk({tag, "_rd"}, rd, erd);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, eer});
  endtask

  logic [31:0] rd;
  logic [9:0]  ack_seen;
  int          acks;

  initial begin
    bus_a.REQ_i = 1'b0; bus_a.WRT_ENA_i = 1'b0; bus_a.FUNCT3_i = 3'd0;
    bus_a.ADDR_i = 32'd0; bus_a.WRT_DATA_i = 32'd0;
    bus_b.REQ_i = 1'b0; bus_b.WRT_ENA_i = 1'b0; bus_b.FUNCT3_i = 3'd0;
    bus_b.ADDR_i = 32'd0; bus_b.WRT_DATA_i = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {bus_a.RD_DATA_o[29:0], bus_a.ACK_o, bus_a.BUSY_o}, 32'd0);
    chk("rst_err", {31'd0, bus_a.ERR_o}, 32'd0);
    rst = 1'b0;

    // Give every word a known random value.
    for (int i = 0; i < 256; i++) xact("fill", 1'b1, 3'd2, 32'(i * 4), $urandom, rd);

    // Word store then load.
    xact("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd);
    xact("lw10", 1'b0, 3'd2, 32'h10, 32'h0, rd);
    chk("lw10_lit", rd, 32'hDEADBEEF);

    // Sub-word lanes and extension.
    xact("sb11", 1'b1, 3'd0, 32'h11, 32'hAAAA_AA7F, rd);
    chk("sb11_lit", rd, 32'h0);
    xact("lb11", 1'b0, 3'd0, 32'h11, 32'h0, rd);
    chk("lb11_lit", rd, 32'h0000007F);
    xact("lw10b", 1'b0, 3'd2, 32'h10, 32'h0, rd);
    chk("lw10b_lit", rd, 32'hDEAD7FEF);
    xact("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, rd);
    chk("lbu13_lit", rd, 32'h000000DE);
    xact("lh12", 1'b0, 3'd1, 32'h12, 32'h0, rd);
    chk("lh12_lit", rd, 32'hFFFFDEAD);
    xact("lhu12", 1'b0, 3'd5, 32'h12, 32'h0, rd);
    chk("lhu12_lit", rd, 32'h0000DEAD);

    // Reset landing on the final ACCESS edge of a store.
    bus_a.REQ_i = 1'b1; bus_a.WRT_ENA_i = 1'b1; bus_a.FUNCT3_i = 3'd2;
    bus_a.ADDR_i = 32'h20; bus_a.WRT_DATA_i = 32'h12345678;
    @(posedge clk); #1;
    bus_a.REQ_i = 1'b0;
    repeat (WA) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", {bus_a.RD_DATA_o[29:0], bus_a.ACK_o, bus_a.BUSY_o}, 32'd0);
    rst = 1'b0;
    acks = 0;
    repeat (6) begin @(posedge clk); #1; if (bus_a.ACK_o) acks++; end
    chk("abort_no_ack", acks, 0);
    xact("lw20", 1'b0, 3'd2, 32'h20, 32'h0, rd);

    // Misaligned word load.
    xact("lw22", 1'b0, 3'd2, 32'h22, 32'h0, rd);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lw22_lit", rd, 32'h0);
`else
    chk("lw22_lit", rd, {mbytes[35], mbytes[34], mbytes[33], mbytes[32]});
`endif

    // Illegal function codes.
    xact("ld_f3", 1'b0, 3'd3, 32'h10, 32'h0, rd);
    chk("ld_f3_lit", rd, 32'h0);
    xact("st_f5", 1'b1, 3'd5, 32'h10, 32'h01020304, rd);
    xact("st_f5_chk", 1'b0, 3'd2, 32'h10, 32'h0, rd);
    chk("st_f5_lit", rd, 32'hDEAD7FEF);

    // Held request on the zero-wait instance: accepts every third edge.
    @(posedge clk); #1;
    bus_b.REQ_i = 1'b1; bus_b.WRT_ENA_i = 1'b1; bus_b.FUNCT3_i = 3'd2;
    bus_b.ADDR_i = 32'h40; bus_b.WRT_DATA_i = 32'hCAFEF00D;
    ack_seen = '0;
    for (int j = 1; j <= 9; j++) begin
      @(posedge clk); #1;
      if (j == 6) bus_b.REQ_i = 1'b0;
      ack_seen[j] = bus_b.ACK_o;
    end
    chk("held_ack_pattern", {22'd0, ack_seen}, 32'h0000_0024);
    chk("held_rd", bus_b.RD_DATA_o, 32'h0);

    // Randomized traffic over the whole address space and every function code.
    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      a = $urandom;
      if (k % 2 == 0) a[31:10] = '0;
      xact("rand", 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
